escaner_display: RTL
====================

# escaner_display

Time-multiplexed scanner for a bank of common-anode seven-segment digits. It latches a hex value from the datapath (register or PC contents) and cycles through its nibbles at a programmable refresh rate. For each digit it presents the active nibble to the downstream 4-bit-to-7-segment decoder and drives the matching active-low anode enable. New values are double-buffered and committed only at frame boundaries, so a digit never shows a mix of old and new data. Optional leading-zero suppression is supported.

## Interface
- DIGITOS, 4: number of digits scanned; legal range 1..8.
- DIV, 50000: clock cycles each digit stays lit; legal range 1..2^20.
- clk_i  input  1  system clock; all state updates on rising edge.
- rst_ni  input  1  reset, asynchronous and active-low.
- dato_i  input  4*DIGITOS  value to show; nibble k (bits 4k+3:4k) drives digit k; digit 0 is least significant.
- carga_i  input  1  load strobe; dato_i is captured on any cycle where carga_i=1.
- supr_ceros_i  input  1  1 = blank leading-zero digits; sampled live, not latched.
- nibble_o  output  4  nibble for the external decoder.
- anodo_o  output  DIGITOS  digit enables, active-low; at most one bit is 0.
- pendiente_o  output  1  a captured value is waiting for the next frame boundary.
- fin_trama_o  output  1  one-cycle pulse when a full scan frame completes.

## Operation
- Internal state:
  - pres, 20 bits, prescaler.
  - indice, 3 bits, current digit.
  - buffer, 4*DIGITOS bits, pending value.
  - mostrado, 4*DIGITOS bits, displayed value.
  - pend, 1 bit, pending flag.
- Prescaler:
  - pres counts 0..DIV-1 and then wraps to 0.
  - tick = (pres == DIV-1).
  - With DIV=1, tick is asserted every cycle.
- Digit scan:
  - On tick, indice advances by 1, wrapping DIGITOS-1 -> 0.
  - The frame ends on the tick where indice == DIGITOS-1.
- Loading:
  - carga_i=1 writes dato_i into buffer and sets pend.
  - Back-to-back or repeated loads before a boundary overwrite buffer; the last one wins.
- Commit at frame end:
  - If pend=1, buffer is copied into mostrado and pend is cleared.
  - If carga_i=1 on the same frame-end cycle, dato_i goes straight into mostrado, buffer is also written, and pend ends at 0. The newest value always wins.
- Blanking:
  - Digit k (k≥1) is blanked when supr_ceros_i=1 and nibbles k..DIGITOS-1 of mostrado are all zero.
  - Digit 0 is never blanked.
  - A blanked digit keeps its anode bit at 1; nibble_o still carries its nibble.
- Outputs (all registered):
  - nibble_o <= mostrado nibble[indice].
  - anodo_o <= ~(1<<indice), or all ones if the digit is blanked.
  - fin_trama_o <= 1 for exactly one cycle per frame.
- Reset (asynchronous assert, clocked release):
  - pres=0, indice=0, buffer=0, mostrado=0, pend=0.
  - nibble_o=4'h0, anodo_o=all ones, pendiente_o=0, fin_trama_o=0.
- Reset asserted mid-frame aborts the scan and discards any pending value.

## Timing
- Outputs lag internal state by 1 cycle.
  - First rising edge after reset release: anodo_o becomes ~1 (digit 0 on), nibble_o becomes 0.
- Each digit is lit for exactly DIV cycles; one frame is DIGITOS*DIV cycles.
- pendiente_o rises 1 cycle after the carga_i edge. It falls on the same edge that loads mostrado, i.e. the cycle fin_trama_o is 1.
- The first digit of the new value appears on nibble_o in the cycle after fin_trama_o, starting with digit 0.
- Load-to-display latency: between 1 and DIGITOS*DIV+1 cycles, depending on frame position.
- supr_ceros_i change: affects anodo_o 1 cycle later, at any point in the frame.
- No handshake back-pressure: carga_i is never refused.

## Test plan
All scenarios use DIGITOS=4, DIV=3.
- Reset with rst_ni=0 and a clock running: anodo_o=4'b1111, nibble_o=0, pendiente_o=0. After release, anodo_o steps 1110, 1101, 1011, 0111, 3 cycles each, all with nibble_o=0; fin_trama_o pulses once per 12 cycles.
- Mid-frame load of carga_i with dato_i=16'h1234: pendiente_o=1 until the next fin_trama_o. Then nibble_o shows 4, 3, 2, 1 with anodo_o 1110, 1101, 1011, 0111.
- Leading-zero suppression with mostrado=16'h0050 and supr_ceros_i=1: digits 3 and 2 show anodo_o=1111; digit 1 shows 1101 with nibble 5; digit 0 shows 1110 with nibble 0. With supr_ceros_i=0, all four digits are lit.
- Load on the frame-end cycle with carga_i=1 and dato_i=16'hABCD: pendiente_o stays 0 and the next frame shows D, C, B, A. Also load 16'h1111 then 16'h2222 within one frame: only 2222 is displayed.
- Reset mid-operation after loading 16'h9999 with pendiente_o=1: drop rst_ni for 1 cycle. All outputs return to reset values immediately (asynchronously), and 9999 is never displayed.
- Edge parameters with DIV=1, DIGITOS=1: anodo_o is constantly 0, and fin_trama_o is 1 every cycle after the first.

Source files
------------

// File: rtl/escaner_display.sv
// Time-multiplexed scanner for a bank of common-anode seven-segment digits.
// Double-buffers the shown value, commits it on frame boundaries, and can blank leading zeros.
module escaner_display #(
   parameter int unsigned DIGITOS = 4,
   parameter int unsigned DIV     = 50000
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [4*DIGITOS-1:0]   dato_i,
   input  logic                   carga_i,
   input  logic                   supr_ceros_i,
   output logic [3:0]             nibble_o,
   output logic [DIGITOS-1:0]     anodo_o,
   output logic                   pendiente_o,
   output logic                   fin_trama_o
);

   localparam int unsigned AW = 4 * DIGITOS;
   localparam int unsigned PW = 20;
   localparam int unsigned IW = 3;
   localparam logic [PW-1:0] PRES_MAX = PW'(DIV - 1);
   localparam logic [IW-1:0] IND_MAX  = IW'(DIGITOS - 1);

   logic [PW-1:0]      pres_q, pres_d;
   logic [IW-1:0]      indice_q, indice_d;
   logic [AW-1:0]      buffer_q, buffer_d;
   logic [AW-1:0]      mostrado_q, mostrado_d;
   logic               pend_q, pend_d;
   logic               tick_c;
   logic               fin_trama_c;
   logic [3:0]         nibble_d;
   logic [DIGITOS-1:0] anodo_d;
   logic [DIGITOS-1:0] onehot_c;
   logic [DIGITOS-1:0] blank_c;
   logic               zeros_c;

   // Prescaler and digit index; a frame ends on the tick of the last digit.
   always_comb begin
      tick_c      = (pres_q == PRES_MAX);
      fin_trama_c = tick_c && (indice_q == IND_MAX);
      pres_d      = tick_c ? '0 : pres_q + PW'(1);
      indice_d    = indice_q;
      if (tick_c) begin
         indice_d = (indice_q == IND_MAX) ? '0 : indice_q + IW'(1);
      end
   end

   // Load buffer and frame-boundary commit; a load on the boundary bypasses the buffer.
   always_comb begin
      buffer_d   = buffer_q;
      mostrado_d = mostrado_q;
      pend_d     = pend_q;
      if (carga_i) begin
         buffer_d = dato_i;
      end
      if (fin_trama_c) begin
         pend_d = 1'b0;
         if (carga_i) begin
            mostrado_d = dato_i;
         end else if (pend_q) begin
            mostrado_d = buffer_q;
         end
      end else if (carga_i) begin
         pend_d = 1'b1;
      end
   end

   // Digit select, leading-zero blanking and next output values.
   always_comb begin
      nibble_d = 4'h0;
      onehot_c = '0;
      blank_c  = '0;
      zeros_c  = 1'b1;
      for (int k = int'(DIGITOS) - 1; k >= 0; k--) begin
         zeros_c    = zeros_c && (mostrado_q[4*k +: 4] == 4'h0);
         blank_c[k] = supr_ceros_i && zeros_c && (k != 0);
      end
      for (int k = 0; k < int'(DIGITOS); k++) begin
         onehot_c[k] = (indice_q == IW'(k));
         if (indice_q == IW'(k)) begin
            nibble_d = mostrado_q[4*k +: 4];
         end
      end
      anodo_d = (|(onehot_c & blank_c)) ? '1 : ~onehot_c;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pres_q     <= '0;
         indice_q   <= '0;
         buffer_q   <= '0;
         mostrado_q <= '0;
         pend_q     <= 1'b0;
      end else begin
         pres_q     <= pres_d;
         indice_q   <= indice_d;
         buffer_q   <= buffer_d;
         mostrado_q <= mostrado_d;
         pend_q     <= pend_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         nibble_o    <= 4'h0;
         anodo_o     <= '1;
         pendiente_o <= 1'b0;
         fin_trama_o <= 1'b0;
      end else begin
         nibble_o    <= nibble_d;
         anodo_o     <= anodo_d;
         pendiente_o <= pend_d;
         fin_trama_o <= fin_trama_c;
      end
   end

endmodule
